// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO user and fifo_ctrl.
// The master issues push/pop requests; the slave (the controller) returns storage control and status.
interface fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 2
);
  // Request semantics: wr/rd are one-cycle requests sampled on every rising edge.
  // A push is taken exactly when wr_en is 1 in that cycle. A pop is taken when rd is 1 and empty is 0.
  // Rejected requests are not retried; they only set the sticky error flags.
  logic                  wr;
  logic                  rd;
  logic                  clr_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, rd, clr_err,
    input  wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, rd, clr_err,
    output wr_en, w_addr, r_addr, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/status controller that turns an external register-file array into a synchronous FWFT FIFO.
// All status is derived from the registered occupancy count; only wr_en is combinational.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int AFULL_LVL  = 2**ADDR_WIDTH-1,
  parameter int AEMPTY_LVL = 1
) (
  input logic        clk,
  input logic        reset,
  fifo_ctrl_if.slave bus
);
  localparam int              CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH    = CW'(2**ADDR_WIDTH);
  localparam logic [CW-1:0]   AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0]   AEMPTY_C = CW'(AEMPTY_LVL);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [CW-1:0]         w_count_nxt;

  // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
  assign w_push_ok = bus.wr & (~r_full | bus.rd);
  assign w_pop_ok  = bus.rd & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + ADDR_WIDTH'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + ADDR_WIDTH'(1);
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AFULL_C);
      r_aempty <= (w_count_nxt <= AEMPTY_C);
      // A new error in the same cycle as clr_err keeps the flag set.
      r_ovf    <= (r_ovf & ~bus.clr_err) | (bus.wr & ~w_push_ok);
      r_unf    <= (r_unf & ~bus.clr_err) | (bus.rd & ~w_pop_ok);
    end
  end

  assign bus.wr_en        = w_push_ok & ~reset;
  assign bus.w_addr       = r_wptr;
  assign bus.r_addr       = r_rptr;
  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a local storage array, a queue reference model and directed plus random traffic.
module tb_fifo_ctrl;
  localparam int AW = 2;
  localparam int D  = 4;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic [7:0] mem [D];
  logic [7:0] head;

  logic [7:0] exp_q [$];
  logic [AW-1:0] m_wptr;
  logic [AW-1:0] m_rptr;
  logic       m_ovf;
  logic       m_unf;
  int         n_checks;
  int         n_fail;
  int         wraps;

  fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(.ADDR_WIDTH(AW), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // storage array in front of which the controller sits
  always @(posedge clk) if (bus.wr_en) mem[bus.w_addr] <= din;
  assign head = mem[bus.r_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check("count",        32'(bus.count),        32'(sz));
    check("full",         32'(bus.full),         32'(sz == D));
    check("empty",        32'(bus.empty),        32'(sz == 0));
    check("almost_full",  32'(bus.almost_full),  32'(sz >= 3));
    check("almost_empty", 32'(bus.almost_empty), 32'(sz <= 1));
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_unf));
    check("w_addr",       32'(bus.w_addr),       32'(m_wptr));
    check("r_addr",       32'(bus.r_addr),       32'(m_rptr));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wptr = '0;
    m_rptr = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // one cycle of traffic: drive at negedge, check comb outputs, then registered state after the edge
  task automatic step(input logic wr_i, input logic rd_i, input logic [7:0] din_i, input logic clr_i);
    logic push_ok;
    logic pop_ok;
    logic [7:0] exp_d;
    @(negedge clk);
    bus.wr      = wr_i;
    bus.rd      = rd_i;
    bus.clr_err = clr_i;
    din         = din_i;
    push_ok = wr_i && ((exp_q.size() < D) || rd_i);
    pop_ok  = rd_i && (exp_q.size() > 0);
    #1;
    check("wr_en", 32'(bus.wr_en), 32'(push_ok));
    if (pop_ok) begin
      exp_d = exp_q.pop_front();
      check("rd_data", 32'(head), 32'(exp_d));
      m_rptr = m_rptr + 1'b1;
    end
    if (push_ok) begin
      exp_q.push_back(din_i);
      m_wptr = m_wptr + 1'b1;
      if (m_wptr == '0) wraps++;
    end
    m_ovf = (m_ovf & ~clr_i) | (wr_i & ~push_ok);
    m_unf = (m_unf & ~clr_i) | (rd_i & ~pop_ok);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wraps    = 0;
    din      = '0;
    bus.wr      = 1'b1;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    reset       = 1'b1;
    model_reset();

    // reset state, wr_en held off even with wr asserted
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_state();
    @(negedge clk);
    bus.wr = 1'b0;
    reset  = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // asynchronous reset mid-stream at count=3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0);
    @(negedge clk);
    bus.wr = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_state();
    @(negedge clk);
    bus.wr = 1'b0;
    reset  = 1'b0;

    // fill, then overflow
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    check("fill_full", 32'(bus.full), 32'd1);
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    check("ovf_set", 32'(bus.overflow), 32'd1);

    // drain, then underflow, then clear
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("unf_set", 32'(bus.underflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("err_cleared", 32'({bus.overflow, bus.underflow}), 32'd0);

    // simultaneous push/pop while full
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'hB0, 1'b0);
    check("sim_full_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // simultaneous push/pop while empty
    step(1'b1, 1'b1, 8'hC0, 1'b0);
    check("sim_empty_unf", 32'(bus.underflow), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // random soak against the queue model
    wraps = 0;
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) == 0));
    check("ptr_wraps", 32'(wraps >= 2), 32'd1);

    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
